// File: rtl/waveform_synth.sv
// Sample generator: turns rising edges of the divider's tick into phase steps
// and emits one sample of the selected waveform per step.
module waveform_synth #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             en,
    input  logic [2:0]       sel,
    input  logic [WIDTH-1:0] duty,
    output logic [WIDTH-1:0] wave,
    output logic             valid
);

    localparam logic [WIDTH-1:0] Max = '1;

    typedef enum logic {StUp, StDown} dir_e;

    logic             s1, s2, s3;
    logic             step;
    logic             init_q;
    logic [2:0]       sel_q;
    logic             mode_chg;
    logic [WIDTH-1:0] phase_q;
    logic [WIDTH-1:0] tri_q, tri_d;
    dir_e             dir_q, dir_d;
    logic [WIDTH-1:0] sample;

    assign step = s2 & ~s3 & en;
    // init_q forces the first edge after reset to behave as a mode change
    assign mode_chg = init_q | (sel != sel_q);

    always_comb begin
        sample = '0;
        case (sel_q)
            3'd0:    sample = phase_q;
            3'd1:    sample = ~phase_q;
            3'd2:    sample = tri_q;
            3'd3:    sample = phase_q[WIDTH-1] ? '0 : Max;
            3'd4:    sample = (phase_q < duty) ? Max : '0;
            3'd5:    sample = {phase_q[WIDTH-1 -: 3], {(WIDTH-3){1'b0}}};
            default: sample = '0;
        endcase
    end

    always_comb begin
        dir_d = dir_q;
        tri_d = tri_q;
        if (mode_chg) begin
            dir_d = StUp;
            tri_d = '0;
        end else if (step) begin
            case (dir_q)
                StUp: begin
                    tri_d = tri_q + 1'b1;
                    if (tri_q == Max - 1'b1) dir_d = StDown;
                end
                StDown: begin
                    tri_d = tri_q - 1'b1;
                    if (tri_q == {{(WIDTH-1){1'b0}}, 1'b1}) dir_d = StUp;
                end
                default: dir_d = StUp;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir_q <= StUp;
            tri_q <= '0;
        end else begin
            dir_q <= dir_d;
            tri_q <= tri_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            s3      <= 1'b0;
            init_q  <= 1'b1;
            sel_q   <= '0;
            phase_q <= '0;
            wave    <= '0;
            valid   <= 1'b0;
        end else begin
            s1    <= tick;
            s2    <= s1;
            s3    <= s2;
            valid <= 1'b0;
            if (mode_chg) begin
                init_q  <= 1'b0;
                sel_q   <= sel;
                phase_q <= '0;
            end else if (step) begin
                wave    <= sample;
                valid   <= 1'b1;
                phase_q <= phase_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_waveform_synth.sv
// Directed bench for waveform_synth: expected samples are queued as ticks are
// driven and checked against each valid strobe.
module tb_waveform_synth;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       en = 1'b1;
    logic [2:0] sel = 3'd0;
    logic [7:0] duty = 8'd0;
    logic [7:0] wave;
    logic       valid;

    int n_cmp = 0;
    int n_bad = 0;
    int valid_cnt = 0;
    logic [7:0] exp_q[$];

    waveform_synth #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .tick(tick), .en(en),
        .sel(sel), .duty(duty), .wave(wave), .valid(valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Scoreboard: every valid strobe pops one expected sample
    always @(negedge clk) begin
        if (valid) begin
            valid_cnt++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $error("FAIL unexpected_valid: observed wave %0d expected no strobe", wave);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                assert (wave === e) else begin
                    n_bad++;
                    $error("FAIL sample: observed %0d expected %0d", wave, e);
                end
            end
        end
    end

    task automatic pulse_tick();
        tick = 1'b1;
        repeat (4) @(negedge clk);
        tick = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic drain(input string tag);
        repeat (6) @(negedge clk);
        check(tag, exp_q.size(), 0);
    endtask

    initial begin
        int base;
        int v;

        // Reset state
        #1;
        check("reset_wave", wave, 0);
        check("reset_valid", valid, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Saw, first tick also measures latency
        base = valid_cnt;
        exp_q.push_back(8'd0);
        @(posedge clk);
        #1 tick = 1'b1;
        @(posedge clk);
        #1 check("lat_edge_n", valid, 0);
        @(posedge clk);
        #1 check("lat_edge_n1", valid, 0);
        @(posedge clk);
        #1 check("lat_edge_n2", valid, 1);
        check("lat_wave", wave, 0);
        @(negedge clk);
        repeat (3) @(negedge clk);
        tick = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 1; i < 300; i++) begin
            exp_q.push_back(8'(i % 256));
            pulse_tick();
        end
        drain("saw_drain");
        check("saw_count", valid_cnt - base, 300);

        // Triangle
        sel = 3'd2;
        repeat (4) @(negedge clk);
        base = valid_cnt;
        for (int i = 0; i < 520; i++) begin
            v = i % 510;
            exp_q.push_back(8'((v <= 255) ? v : 510 - v));
            pulse_tick();
        end
        drain("tri_drain");
        check("tri_count", valid_cnt - base, 520);

        // Pulse, duty 64 then duty 0
        sel = 3'd4;
        duty = 8'd64;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 256; i++) begin
            exp_q.push_back((i < 64) ? 8'd255 : 8'd0);
            pulse_tick();
        end
        duty = 8'd0;
        for (int i = 0; i < 256; i++) begin
            exp_q.push_back(8'd0);
            pulse_tick();
        end
        drain("pulse_drain");

        // Mode change coinciding with a step
        sel = 3'd0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 100; i++) begin
            exp_q.push_back(8'(i));
            pulse_tick();
        end
        drain("mc_pre_drain");
        base = valid_cnt;
        @(posedge clk);
        #1 tick = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 sel = 3'd1;
        @(posedge clk);
        #1 check("mc_valid", valid, 0);
        check("mc_wave_hold", wave, 99);
        @(negedge clk);
        repeat (3) @(negedge clk);
        tick = 1'b0;
        repeat (4) @(negedge clk);
        check("mc_dropped", valid_cnt - base, 0);
        exp_q.push_back(8'd255);
        pulse_tick();
        exp_q.push_back(8'd254);
        pulse_tick();
        drain("mc_post_drain");

        // Tick held high for 50 clocks gives one step
        base = valid_cnt;
        exp_q.push_back(8'd253);
        tick = 1'b1;
        repeat (50) @(negedge clk);
        tick = 1'b0;
        repeat (4) @(negedge clk);
        check("held_count", valid_cnt - base, 1);

        // Enable low freezes generation
        en = 1'b0;
        base = valid_cnt;
        repeat (3) pulse_tick();
        check("en_off_count", valid_cnt - base, 0);
        check("en_off_wave", wave, 253);
        en = 1'b1;
        repeat (2) @(negedge clk);
        exp_q.push_back(8'd252);
        pulse_tick();
        drain("en_on_drain");

        // Async reset in triangle at tri=200 heading down
        sel = 3'd2;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 310; i++) begin
            exp_q.push_back(8'((i <= 255) ? i : 510 - i));
            pulse_tick();
        end
        drain("pre_rst_drain");
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check("rst_wave", wave, 0);
        check("rst_valid", valid, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        exp_q.push_back(8'd0);
        pulse_tick();
        exp_q.push_back(8'd1);
        pulse_tick();
        drain("post_rst_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
